// File: rtl/dmem_responder.sv
// Purpose : word-organised data RAM answering MEM-stage loads/stores with byte-lane store merge.
// Latency : LATENCY wait cycles per access (0 = combinational read, store commits at end of request cycle).
// Backpr. : StallMemM holds every pipeline stage while an access is outstanding; deasserted in the DONE cycle.
// Ports   : clk, reset (sync, active-high); MemReadM/MemWriteM request, ALUResultM byte address,
//           WriteDataM/ByteEnM store data and lane enables; ReadDataM load word, StallMemM stall,
//           FaultM one-cycle pulse for an access outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [3:0]  ByteEnM,
   output logic [31:0] ReadDataM,
   output logic        StallMemM,
   output logic        FaultM
);

   localparam int unsigned AW    = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

   logic [31:0]   mem [DEPTH_WORDS];
   logic          req;
   logic [31:0]   off;
   logic          in_range;
   logic [AW-1:0] idx;
   logic          perform;
   logic          wr_en;
   logic          unused_bits;

   assign req = MemReadM | MemWriteM;
   assign off = ALUResultM - BASE_ADDR;
   // The lower-bound test catches addresses below the window, whose offset wraps.
   assign in_range = (ALUResultM >= BASE_ADDR) && ({1'b0, off} < LIMIT);
   assign idx = off[AW+1:2];
   // Byte offset within the word and the bits above the window are not part of the index.
   assign unused_bits = ^{off[1:0], off[31:AW+2]};

   // Out-of-range stores are dropped; a store caught by reset on its perform edge is discarded.
   assign wr_en = perform & MemWriteM & in_range & ~reset;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (ByteEnM[i]) begin
               mem[idx][8*i +: 8] <= WriteDataM[8*i +: 8];
            end
         end
      end
   end

   generate
      if (LATENCY == 0) begin : g_zero
         assign perform   = req;
         assign StallMemM = 1'b0;
         assign FaultM    = req & ~in_range;
         // A combined read+write is a store, so it returns zero like an out-of-range load.
         assign ReadDataM = (MemReadM & ~MemWriteM & in_range) ? mem[idx] : 32'h0;
      end else begin : g_fsm
         typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

         state_t      state;
         logic [7:0]  cnt;
         logic [31:0] rdata_q;
         logic        fault_q;

         // The access happens on the last stall edge; with LATENCY==1 that is the IDLE edge itself.
         assign perform   = ((state == IDLE) && req && (LATENCY == 1)) ||
                            ((state == BUSY) && (cnt == 8'd1));
         assign StallMemM = ((state == IDLE) && req) || (state == BUSY);
         assign ReadDataM = rdata_q;
         assign FaultM    = fault_q;

         always_ff @(posedge clk) begin
            if (reset) begin
               state   <= IDLE;
               cnt     <= 8'd0;
               rdata_q <= 32'h0;
               fault_q <= 1'b0;
            end else begin
               // Set on the perform edge only, so it is high for exactly the DONE cycle.
               fault_q <= perform & ~in_range;
               if (perform && MemReadM) begin
                  rdata_q <= (MemWriteM || !in_range) ? 32'h0 : mem[idx];
               end
               case (state)
                  IDLE: begin
                     if (req) begin
                        if (LATENCY == 1) begin
                           state <= DONE;
                        end else begin
                           cnt   <= 8'(LATENCY - 1);
                           state <= BUSY;
                        end
                     end
                  end
                  BUSY: begin
                     cnt <= cnt - 8'd1;
                     if (cnt == 8'd1) begin
                        state <= DONE;
                     end
                  end
                  // The request still present here is the finished access; never restart it.
                  DONE:    state <= IDLE;
                  default: state <= IDLE;
               endcase
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
// Purpose : bench for dmem_responder across LATENCY 0..3 with a word-array reference model.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_dmem_responder;

   localparam int NK    = 4;
   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst  [NK];
   logic        rd   [NK];
   logic        wr   [NK];
   logic [31:0] addr [NK];
   logic [31:0] wdat [NK];
   logic [3:0]  be   [NK];
   logic [31:0] rdat [NK];
   logic        stall[NK];
   logic        fault[NK];

   always #5 clk = ~clk;

   // Instance k has LATENCY k; instance 0 also sits at a non-zero base address.
   genvar g;
   for (g = 0; g < NK; g++) begin : g_dut
      dmem_responder #(
         .DEPTH_WORDS(DEPTH),
         .LATENCY    (g),
         .BASE_ADDR  ((g == 0) ? 32'h100 : 32'h0)
      ) u_dut (
         .clk       (clk),
         .reset     (rst[g]),
         .MemReadM  (rd[g]),
         .MemWriteM (wr[g]),
         .ALUResultM(addr[g]),
         .WriteDataM(wdat[g]),
         .ByteEnM   (be[g]),
         .ReadDataM (rdat[g]),
         .StallMemM (stall[g]),
         .FaultM    (fault[g])
      );
   end

   int          n_checks = 0;
   int          n_err    = 0;
   logic [31:0] model    [NK][DEPTH];
   logic [31:0] model_rd [NK];

   function automatic logic [31:0] base_of(int k);
      return (k == 0) ? 32'h100 : 32'h0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic go_idle();
      @(posedge clk);
      #1;
      for (int j = 0; j < NK; j++) begin
         rd[j] = 1'b0;
         wr[j] = 1'b0;
      end
   endtask

   // One access on instance k, held until the first non-stall cycle, then checked there.
   task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b, input string tag);
      longint      lo, hi, aa;
      bit          inr, early, done;
      int          idx, nst;
      logic [31:0] exp_rd;
      aa  = longint'(a);
      lo  = longint'(base_of(k));
      hi  = lo + 4 * DEPTH;
      inr = (aa >= lo) && (aa < hi);
      idx = inr ? int'((aa - lo) / 4) : 0;
      exp_rd = (w || !inr) ? 32'h0 : model[k][idx];
      if (w && inr) begin
         for (int i = 0; i < 4; i++) begin
            if (b[i]) model[k][idx][8*i +: 8] = d[8*i +: 8];
         end
      end
      if (r) model_rd[k] = exp_rd;

      @(posedge clk);
      #1;
      for (int j = 0; j < NK; j++) begin
         if (j != k) begin
            rd[j] = 1'b0;
            wr[j] = 1'b0;
         end
      end
      rd[k] = r; wr[k] = w; addr[k] = a; wdat[k] = d; be[k] = b;

      nst = 0; early = 1'b0; done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (stall[k] === 1'b1) begin
            nst++;
            if (fault[k] !== 1'b0) early = 1'b1;
         end else begin
            done = 1'b1;
         end
      end
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " stall_cycles"}, 32'(nst), 32'(k));
      chk({tag, " early_fault"}, 32'(early), 32'd0);
      chk({tag, " fault"}, {31'b0, fault[k]}, inr ? 32'd0 : 32'd1);
      if (r || k != 0) begin
         chk({tag, " rdata"}, rdat[k], (k == 0) ? exp_rd : model_rd[k]);
      end
   endtask

   initial begin
      logic [31:0] a, d, v;
      int          k, op;
      bit          r, w;

      for (int j = 0; j < NK; j++) begin
         rst[j] = 1'b1; rd[j] = 1'b0; wr[j] = 1'b0;
         addr[j] = 32'h0; wdat[j] = 32'h0; be[j] = 4'h0;
         model_rd[j] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int j = 0; j < NK; j++) rst[j] = 1'b0;

      @(negedge clk);
      for (int j = 0; j < NK; j++) begin
         chk($sformatf("reset stall k%0d", j), {31'b0, stall[j]}, 32'd0);
         chk($sformatf("reset fault k%0d", j), {31'b0, fault[j]}, 32'd0);
         if (j != 0) chk($sformatf("reset rdata k%0d", j), rdat[j], 32'h0);
      end

      // Known contents everywhere so every later load is checkable.
      for (int j = 0; j < NK; j++) begin
         for (int i = 0; i < DEPTH; i++) begin
            access(j, 1'b0, 1'b1, base_of(j) + 32'(4 * i), $urandom, 4'hF,
                   $sformatf("preload k%0d w%0d", j, i));
         end
      end

      access(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "lat2 st10");
      access(2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "lat2 ld10");
      chk("lat2 ld10 literal", rdat[2], 32'hDEADBEEF);

      access(2, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, "lat2 pre20");
      access(2, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "lat2 merge20");
      access(2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, "lat2 ld20");
      chk("lat2 merge literal", rdat[2], 32'h11BB33DD);

      access(0, 1'b0, 1'b1, 32'h104, 32'hCAFEF00D, 4'hF, "lat0 st");
      access(0, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0, "lat0 ld");
      chk("lat0 ld literal", rdat[0], 32'hCAFEF00D);

      access(1, 1'b0, 1'b1, 32'h8, 32'h12345678, 4'h0, "lat1 be0 st");
      access(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, "lat1 be0 ld");

      for (int j = 0; j < NK; j++) begin
         access(j, 1'b1, 1'b0, base_of(j) + 32'(4 * DEPTH), 32'h0, 4'h0, $sformatf("oor ld k%0d", j));
         go_idle();
         @(negedge clk);
         chk($sformatf("oor pulse end k%0d", j), {31'b0, fault[j]}, 32'd0);
         access(j, 1'b0, 1'b1, base_of(j) + 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, $sformatf("oor st k%0d", j));
         access(j, 1'b1, 1'b0, base_of(j), 32'h0, 4'h0, $sformatf("oor keep k%0d", j));
      end
      access(0, 1'b0, 1'b1, 32'hFC, 32'hFFFFFFFF, 4'hF, "lat0 below base st");
      access(0, 1'b1, 1'b0, 32'h17C, 32'h0, 4'h0, "lat0 top word ld");

      for (int j = 1; j < NK; j++) begin
         access(j, 1'b1, 1'b1, 32'h30, 32'h5A5A5A5A, 4'b0011, $sformatf("both k%0d", j));
         go_idle();
         @(negedge clk);
         chk($sformatf("both no restall k%0d", j), {31'b0, stall[j]}, 32'd0);
         access(j, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, $sformatf("both ld k%0d", j));
      end

      // Reset in the second BUSY cycle of a LATENCY=3 store.
      go_idle();
      v = model[3][16];
      @(posedge clk);
      #1;
      wr[3] = 1'b1; addr[3] = 32'h40; wdat[3] = ~v; be[3] = 4'hF;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst[3] = 1'b1;
      @(negedge clk);
      chk("rst busy stall", {31'b0, stall[3]}, 32'd1);
      @(posedge clk);
      #1;
      rst[3] = 1'b0;
      wr[3]  = 1'b0;
      @(negedge clk);
      chk("rst after stall", {31'b0, stall[3]}, 32'd0);
      chk("rst after fault", {31'b0, fault[3]}, 32'd0);
      chk("rst after rdata", rdat[3], 32'h0);
      model_rd[3] = 32'h0;
      access(3, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, "rst target ld");
      chk("rst target literal", rdat[3], v);

      for (int it = 0; it < 200; it++) begin
         k  = $urandom_range(0, NK - 1);
         op = $urandom_range(0, 2);
         r  = (op != 1);
         w  = (op != 0);
         if ($urandom_range(0, 9) == 0) begin
            a = base_of(k) + 32'(4 * DEPTH) + 32'($urandom_range(0, 31));
         end else begin
            a = base_of(k) + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
         end
         d = $urandom;
         access(k, r, w, a, d, 4'($urandom_range(0, 15)), $sformatf("rnd%0d k%0d", it, k));
      end

      go_idle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
